alu32: RTL and testbench



---
 rtl/alu32.sv | 87 ++++++++
 tb/tb_alu32.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu32.sv
// 32-bit registered ALU: add, sub, and, xor, signed set-less-than and pass-through.
// One-cycle latency; result and carry held in output registers with async reset.
module alu32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpXor   = 3'b011,
    OpPassA = 3'b100,
    OpSlt   = 3'b101,
    OpPassB = 3'b110,
    OpPassX = 3'b111
  } op_e;

  op_e             w_op;
  logic            w_sub_mode;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]  w_sum_full;
  logic [WIDTH-1:0] w_sum;
  logic            w_carry;
  logic            w_ovf;
  logic            w_lt;
  logic [WIDTH-1:0] w_result_d;
  logic            w_cout_d;
  logic [WIDTH-1:0] r_result;
  logic            r_cout;

  assign w_op = op_e'(alu);

  // ADD, SUB and SLT share one adder; SUB/SLT invert b and inject carry-in.
  assign w_sub_mode = (w_op == OpSub) || (w_op == OpSlt);
  assign w_b_eff    = w_sub_mode ? ~b : b;
  assign w_sum_full = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub_mode};
  assign w_sum      = w_sum_full[WIDTH-1:0];
  assign w_carry    = w_sum_full[WIDTH];

  // True sign of a-b corrects the raw sum sign when the subtraction overflows.
  assign w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_lt  = w_sum[WIDTH-1] ^ w_ovf;

  always_comb begin
    w_result_d = '0;
    w_cout_d   = 1'b0;
    case (w_op)
      OpAdd: begin
        w_result_d = w_sum;
        w_cout_d   = w_carry;
      end
      OpSub: begin
        w_result_d = w_sum;
        w_cout_d   = w_carry;
      end
      OpAnd:   w_result_d = a & b;
      OpXor:   w_result_d = a ^ b;
      OpPassA: w_result_d = a;
      OpSlt:   w_result_d = {{(WIDTH-1){1'b0}}, w_lt};
      OpPassB: w_result_d = b;
      OpPassX: w_result_d = a;
      default: w_result_d = a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_result <= w_result_d;
      r_cout   <= w_cout_d;
    end
  end

  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed test-plan cases plus randomized operands
// compared against an arithmetic reference model.
module tb_alu32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = 32'h0000_1234;
  logic [31:0] b   = 32'h0000_0011;
  logic [2:0]  alu = 3'b000;
  logic [31:0] result;
  logic        cout;

  int n_pass  = 0;
  int n_total = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .alu    (alu),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [2:0] op, output logic [31:0] r,
                                output logic c);
    logic [32:0] s;
    c = 1'b0;
    r = x;
    case (op)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[31:0];
        c = s[32];
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
      end
      3'd2: r = x & y;
      3'd3: r = x ^ y;
      3'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6: r = y;
      default: r = x;
    endcase
  endfunction

  // Drive inputs just after an edge; caller samples after the next edge.
  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    a   = x;
    b   = y;
    alu = op;
  endtask

  task automatic test_reset();
    logic [31:0] er;
    logic        ec;
    drive(32'h0000_1234, 32'h0000_0011, 3'd0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (result !== 32'd0 || cout !== 1'b0)
      $display("FAIL reset_immediate: result=%h cout=%b expected 00000000/0", result, cout);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (result !== 32'd0 || cout !== 1'b0)
        $display("FAIL reset_hold: result=%h cout=%b expected 00000000/0", result, cout);
      else n_pass++;
    end
    drive(32'hFFFF_FFFF, 32'h0000_0002, 3'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    model(a, b, alu, er, ec);
    n_total++;
    if (result !== er || cout !== ec)
      $display("FAIL reset_release: result=%h cout=%b expected %h/%b", result, cout, er, ec);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] exp_r [4] = '{32'h0000_00F1, 32'h0000_00EF, 32'h0000_0000, 32'h0000_00F1};
    logic        exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] prev_r;
    prev_r = result;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0000_00F0, 32'h0000_0001, 3'(i));
      #2;
      n_total++;
      if (result !== prev_r)
        $display("FAIL basic_latency op%0d: result=%h expected held %h", i, result, prev_r);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (result !== exp_r[i] || cout !== exp_c[i])
        $display("FAIL basic op%0d: result=%h cout=%b expected %h/%b",
                 i, result, cout, exp_r[i], exp_c[i]);
      else n_pass++;
      prev_r = exp_r[i];
    end
  endtask

  task automatic test_slt();
    logic [31:0] ta [3] = '{32'h0000_00F0, 32'h8000_00F0, 32'h7FFF_FFFF};
    logic [31:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] ex [3] = '{32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], tb[i], 3'b101);
      @(posedge clk); #1;
      n_total++;
      if (result !== ex[i] || cout !== 1'b0)
        $display("FAIL slt case%0d: result=%h cout=%b expected %h/0", i, result, cout, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0005};
    logic [31:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
    logic [2:0]  to [3] = '{3'b000, 3'b001, 3'b001};
    logic [31:0] er [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], tb[i], to[i]);
      @(posedge clk); #1;
      n_total++;
      if (result !== er[i] || cout !== ec[i])
        $display("FAIL carry case%0d: result=%h cout=%b expected %h/%b",
                 i, result, cout, er[i], ec[i]);
      else n_pass++;
    end
  endtask

  task automatic test_pass();
    logic [2:0]  to [3] = '{3'b100, 3'b110, 3'b111};
    logic [31:0] er [3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678};
    for (int i = 0; i < 3; i++) begin
      drive(32'h1234_5678, 32'h9ABC_DEF0, to[i]);
      @(posedge clk); #1;
      n_total++;
      if (result !== er[i] || cout !== 1'b0)
        $display("FAIL pass op%0d: result=%h cout=%b expected %h/0", to[i], result, cout, er[i]);
      else n_pass++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] er;
    logic        ec;
    for (int i = 0; i < 300; i++) begin
      drive(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)));
      model(a, b, alu, er, ec);
      @(posedge clk); #1;
      n_total++;
      if (result !== er || cout !== ec)
        $display("FAIL random op%0d a=%h b=%h: result=%h cout=%b expected %h/%b",
                 alu, a, b, result, cout, er, ec);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic        ec;
    logic [31:0] x;
    logic [31:0] y;
    x = 32'hC000_0003;
    y = 32'h4000_0005;
    for (int i = 0; i < 8; i++) begin
      drive(x, y, 3'(i));
      if (i == 4) begin
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (result !== 32'd0 || cout !== 1'b0)
          $display("FAIL b2b_reset: result=%h cout=%b expected 00000000/0", result, cout);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (result !== 32'd0 || cout !== 1'b0)
          $display("FAIL b2b_reset_hold: result=%h cout=%b expected 00000000/0", result, cout);
        else n_pass++;
        #2 rst = 1'b0;
      end
      model(x, y, 3'(i), er, ec);
      @(posedge clk); #1;
      n_total++;
      if (result !== er || cout !== ec)
        $display("FAIL b2b op%0d: result=%h cout=%b expected %h/%b", i, result, cout, er, ec);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slt();
    test_carry();
    test_pass();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
